// File: rtl/mix_ddc_nch_pkg.sv
// rtl/mix_ddc_nch_pkg.sv - shared constants and round/saturate helper for the DDC mixer
// Holds the quadrant encoding, the reset NCO increment and the rounding helper.
package mix_pkg;

  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  localparam logic [31:0] FREQ_RST_DEF = 32'h4CCC_CCCD;

  // Round-half-up of p >> shift; with sat set the result is clamped to an ow-bit signed range,
  // otherwise the caller keeps the low ow bits and the value wraps.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] p,
                                                   input int shift,
                                                   input int ow,
                                                   input bit sat);
    logic signed [63:0] t;
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    t  = p >>> (shift - 1);
    r  = (t >>> 1) + $signed({63'd0, t[0]});
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (sat) begin
      if (r > hi) r = hi;
      else if (r < lo) r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/mix_ddc_nch_sincos_lut.sv
// rtl/mix_ddc_nch_sincos_lut.sv - quarter-wave sin/cos ROM with quadrant unfolding
// Stage S1 registers both mirrored ROM reads, stage S2 applies the quadrant signs.
module mix_sincos_lut
  import mix_pkg::*;
#(
  parameter int CW     = 16,
  parameter int LUT_AW = 10
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [1:0]           quad_i,
  input  logic [LUT_AW-1:0]    addr_i,
  output logic signed [CW-1:0] sin_o,
  output logic signed [CW-1:0] cos_o
);

  localparam int  DEPTH   = 1 << LUT_AW;
  localparam real HALF_PI = 1.5707963267948966;

  // Half-sample offset keeps the table symmetric so L[~a] is the cosine mirror of L[a].
  function automatic logic [CW-1:0] lut_entry(input int k);
    real amp;
    real x;
    amp = (2.0 ** (CW - 1)) - 1.0;
    x   = amp * $sin(HALF_PI * (real'(k) + 0.5) / real'(DEPTH));
    return CW'($rtoi(x + 0.5));
  endfunction

  logic [CW-1:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign rom[k] = lut_entry(k);
  end

  logic [CW-1:0] sin_mag_q;
  logic [CW-1:0] cos_mag_q;
  logic [1:0]    quad_q;
  logic [CW-1:0] sin_d;
  logic [CW-1:0] cos_d;
  logic [CW-1:0] sin_q;
  logic [CW-1:0] cos_q;

  always_comb begin
    sin_d = sin_mag_q;
    cos_d = cos_mag_q;
    case (quad_q)
      QUAD_0: begin sin_d = sin_mag_q;  cos_d = cos_mag_q;  end
      QUAD_1: begin sin_d = cos_mag_q;  cos_d = -sin_mag_q; end
      QUAD_2: begin sin_d = -sin_mag_q; cos_d = -cos_mag_q; end
      QUAD_3: begin sin_d = -cos_mag_q; cos_d = sin_mag_q;  end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sin_mag_q <= '0;
      cos_mag_q <= '0;
      quad_q    <= '0;
      sin_q     <= '0;
      cos_q     <= '0;
    end else begin
      sin_mag_q <= rom[addr_i];
      cos_mag_q <= rom[~addr_i];
      quad_q    <= quad_i;
      sin_q     <= sin_d;
      cos_q     <= cos_d;
    end
  end

  assign sin_o = sin_q;
  assign cos_o = cos_q;

endmodule

// File: rtl/mix_ddc_nch.sv
// rtl/mix_ddc_nch.sv - N-channel DDC mixer with programmable NCO, 4-cycle latency
// Build option MIX_SAT_EN: clamp rounded outputs instead of wrapping.
module mix_ddc_nch
  import mix_pkg::*;
#(
  parameter int             NCH       = 2,
  parameter int             DW        = 16,
  parameter int             CW        = 16,
  parameter int             PW        = 32,
  parameter int             LUT_AW    = 10,
  parameter int             OW        = 16,
  parameter int             OUT_SHIFT = 12,
  parameter logic [PW-1:0]  FREQ_RST  = PW'(FREQ_RST_DEF)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IN_VLD,
  input  logic [NCH*DW-1:0]   IN_DAT,
  input  logic                FREQ_WR,
  input  logic [PW-1:0]       FREQ_DAT,
  input  logic                PHASE_CLR,
  output logic                OUT_VLD,
  output logic [NCH*OW-1:0]   OUT_DATI,
  output logic [NCH*OW-1:0]   OUT_DATQ
);

`ifdef MIX_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [PW-1:0]       acc_q, acc_d;
  logic [PW-1:0]       inc_q, inc_d;
  logic [PW-1:0]       shd_q, shd_d;
  logic [PW-1:0]       smp_phase;
  logic [LUT_AW+1:0]   lut_idx;
  logic [3:0]          vld_q;
  logic [NCH*DW-1:0]   dat1_q;
  logic [NCH*DW-1:0]   dat2_q;
  logic signed [CW-1:0] sin_s2;
  logic signed [CW-1:0] cos_s2;

  // The increment is latched from the shadow only on a strobe, after this sample's advance.
  always_comb begin
    smp_phase = PHASE_CLR ? '0 : acc_q;
    acc_d     = IN_VLD ? smp_phase + inc_q : smp_phase;
    inc_d     = IN_VLD ? shd_q : inc_q;
    shd_d     = FREQ_WR ? FREQ_DAT : shd_q;
  end

  assign lut_idx = (LUT_AW+2)'(smp_phase >> (PW - LUT_AW - 2));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_q  <= '0;
      inc_q  <= FREQ_RST;
      shd_q  <= FREQ_RST;
      vld_q  <= '0;
      dat1_q <= '0;
      dat2_q <= '0;
    end else begin
      acc_q  <= acc_d;
      inc_q  <= inc_d;
      shd_q  <= shd_d;
      vld_q  <= {vld_q[2:0], IN_VLD};
      dat1_q <= IN_DAT;
      dat2_q <= dat1_q;
    end
  end

  mix_sincos_lut #(
    .CW     (CW),
    .LUT_AW (LUT_AW)
  ) u_lut (
    .CLK    (CLK),
    .RST    (RST),
    .quad_i (lut_idx[LUT_AW+1 -: 2]),
    .addr_i (lut_idx[LUT_AW-1:0]),
    .sin_o  (sin_s2),
    .cos_o  (cos_s2)
  );

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic signed [DW-1:0]    x_s2;
    logic signed [DW+CW-1:0] prod_i_q;
    logic signed [DW+CW-1:0] prod_q_q;
    logic [OW-1:0]           out_i_q;
    logic [OW-1:0]           out_q_q;

    assign x_s2 = dat2_q[k*DW +: DW];

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        prod_i_q <= '0;
        prod_q_q <= '0;
        out_i_q  <= '0;
        out_q_q  <= '0;
      end else begin
        prod_i_q <= (DW+CW)'(x_s2) * (DW+CW)'(cos_s2);
        prod_q_q <= (DW+CW)'(x_s2) * (DW+CW)'(sin_s2);
        // Outputs only update on valid samples so gaps hold the last result.
        if (vld_q[2]) begin
          out_i_q <= OW'(round_sat(64'(prod_i_q), OUT_SHIFT, OW, SAT_EN));
          out_q_q <= OW'(round_sat(64'(prod_q_q), OUT_SHIFT, OW, SAT_EN));
        end
      end
    end

    assign OUT_DATI[k*OW +: OW] = out_i_q;
    assign OUT_DATQ[k*OW +: OW] = out_q_q;
  end

  assign OUT_VLD = vld_q[3];

endmodule

// File: tb/tb_mix_ddc_nch.sv
// tb/tb_mix_ddc_nch.sv - directed and random stimulus for mix_ddc_nch against a phase-angle model
// Expected outputs come from the sample phase angle and real-valued sin/cos, not from a LUT copy.
module tb_mix_ddc_nch;

  localparam int  NCH    = 2;
  localparam int  DW     = 16;
  localparam int  OW     = 16;
  localparam int  PW     = 32;
  localparam int  SH     = 12;
  localparam real TWO_PI = 6.283185307179586;

  logic              CLK = 1'b0;
  logic              RST;
  logic              IN_VLD;
  logic [NCH*DW-1:0] IN_DAT;
  logic              FREQ_WR;
  logic [PW-1:0]     FREQ_DAT;
  logic              PHASE_CLR;
  logic              OUT_VLD;
  logic [NCH*OW-1:0] OUT_DATI;
  logic [NCH*OW-1:0] OUT_DATQ;

  int vec  = 0;
  int errs = 0;

  typedef struct {
    logic [NCH*OW-1:0] i;
    logic [NCH*OW-1:0] q;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          held;
  logic [PW-1:0] m_acc;
  logic [PW-1:0] m_inc;
  logic [PW-1:0] m_shd;
  logic [3:0]    hist;

  mix_ddc_nch dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VLD    (IN_VLD),
    .IN_DAT    (IN_DAT),
    .FREQ_WR   (FREQ_WR),
    .FREQ_DAT  (FREQ_DAT),
    .PHASE_CLR (PHASE_CLR),
    .OUT_VLD   (OUT_VLD),
    .OUT_DATI  (OUT_DATI),
    .OUT_DATQ  (OUT_DATQ)
  );

  always #5 CLK = ~CLK;

  function automatic longint rnd(input real x);
    if (x >= 0.0) return longint'($rtoi(x + 0.5));
    return -longint'($rtoi(-x + 0.5));
  endfunction

  function automatic logic [OW-1:0] scale(input longint p);
    longint r;
    r = (p + 2048) >>> SH;
`ifdef MIX_SAT_EN
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r[OW-1:0];
  endfunction

  function automatic exp_t model_out(input logic [PW-1:0] ph, input logic [NCH*DW-1:0] dat);
    exp_t   e;
    real    ang;
    longint s;
    longint c;
    longint x;
    int     idx;
    idx = int'(ph >> (PW - 12));
    ang = TWO_PI * (real'(idx) + 0.5) / 4096.0;
    s   = rnd(32767.0 * $sin(ang));
    c   = rnd(32767.0 * $cos(ang));
    e.i = '0;
    e.q = '0;
    for (int k = 0; k < NCH; k++) begin
      x = longint'($signed(dat[k*DW +: DW]));
      e.i[k*OW +: OW] = scale(x * c);
      e.q[k*OW +: OW] = scale(x * s);
    end
    return e;
  endfunction

  function automatic logic [NCH*DW-1:0] rep(input logic [DW-1:0] v);
    return {NCH{v}};
  endfunction

  task automatic model_reset();
    m_acc  = '0;
    m_inc  = 32'h4CCC_CCCD;
    m_shd  = 32'h4CCC_CCCD;
    hist   = '0;
    exp_q.delete();
    held.i = '0;
    held.q = '0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vec++;
    assert (obs === expv)
    else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".vld"}, 64'(OUT_VLD), 64'(hist[3]));
    if (hist[3] && exp_q.size() > 0) held = exp_q.pop_front();
    chk({tag, ".i"}, 64'(OUT_DATI), 64'(held.i));
    chk({tag, ".q"}, 64'(OUT_DATQ), 64'(held.q));
  endtask

  task automatic step(input bit vld, input logic [NCH*DW-1:0] dat, input bit clr,
                      input bit fwr, input logic [PW-1:0] fdat, input string tag);
    logic [PW-1:0] ph;
    @(negedge CLK);
    IN_VLD    = vld;
    IN_DAT    = dat;
    PHASE_CLR = clr;
    FREQ_WR   = fwr;
    FREQ_DAT  = fdat;
    hist = {hist[2:0], vld};
    if (vld) begin
      ph = clr ? '0 : m_acc;
      exp_q.push_back(model_out(ph, dat));
      m_acc = ph + m_inc;
      m_inc = m_shd;
    end else if (clr) begin
      m_acc = '0;
    end
    if (fwr) m_shd = fdat;
    @(posedge CLK);
    #1;
    check_out(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int j = 0; j < n; j++) step(1'b0, '0, 1'b0, 1'b0, '0, tag);
  endtask

  task automatic set_inc(input logic [PW-1:0] f, input string tag);
    step(1'b0, '0, 1'b0, 1'b1, f, tag);
    step(1'b1, '0, 1'b0, 1'b0, '0, tag);
    step(1'b0, '0, 1'b1, 1'b0, '0, tag);
  endtask

  initial begin
    RST       = 1'b1;
    IN_VLD    = 1'b0;
    IN_DAT    = '0;
    PHASE_CLR = 1'b0;
    FREQ_WR   = 1'b0;
    FREQ_DAT  = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset.vld", 64'(OUT_VLD), 64'd0);
    chk("reset.i", 64'(OUT_DATI), 64'd0);
    chk("reset.q", 64'(OUT_DATQ), 64'd0);
    @(negedge CLK);
    RST = 1'b0;

    set_inc(32'h0, "const.setup");
    repeat (8) step(1'b1, rep(16'd1000), 1'b0, 1'b0, '0, "const");
    idle(4, "const.drain");
    chk("const.i_dir", 64'(OUT_DATI), 64'(rep(16'd8000)));
    chk("const.q_dir", 64'(OUT_DATQ), 64'(rep(16'd6)));

    set_inc(32'h4000_0000, "quarter.setup");
    repeat (8) step(1'b1, rep(16'd1000), 1'b0, 1'b0, '0, "quarter");
    idle(4, "quarter.drain");
    chk("quarter.i_dir", 64'(OUT_DATI), 64'(rep(16'd6)));
    chk("quarter.q_dir", 64'(OUT_DATQ), 64'(rep(16'hE0C0)));

    set_inc(32'h0, "max.setup");
    step(1'b1, rep(16'h7FFF), 1'b0, 1'b0, '0, "max");
    idle(4, "max.drain");
`ifdef MIX_SAT_EN
    chk("max.i_dir", 64'(OUT_DATI[OW-1:0]), 64'(16'h7FFF));
`else
    chk("max.i_dir", 64'(OUT_DATI[OW-1:0]), 64'(16'hFFF0));
`endif
    step(1'b1, rep(16'h8000), 1'b0, 1'b0, '0, "min");
    idle(4, "min.drain");
`ifdef MIX_SAT_EN
    chk("min.i_dir", 64'(OUT_DATI[OW-1:0]), 64'(16'h8000));
`else
    chk("min.i_dir", 64'(OUT_DATI[OW-1:0]), 64'(16'h0008));
`endif

    set_inc(32'h1000_0000, "gap.setup");
    step(1'b1, rep(16'd1234), 1'b0, 1'b0, '0, "gap");
    step(1'b0, '0, 1'b0, 1'b1, 32'h2000_0000, "gap");
    step(1'b0, '0, 1'b0, 1'b0, '0, "gap");
    repeat (3) step(1'b1, rep(16'd1234), 1'b0, 1'b0, '0, "gap");
    idle(5, "gap.drain");

    set_inc(32'hFFFF_FFFF, "wrap.setup");
    repeat (10) step(1'b1, $urandom, 1'b0, 1'b0, '0, "wrap");
    idle(4, "wrap.drain");

    for (int n = 0; n < 300; n++) begin
      step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 29) == 0,
           $urandom_range(0, 19) == 0, $urandom, "random");
    end

    repeat (3) step(1'b1, $urandom, 1'b0, 1'b0, '0, "midrst.pre");
    @(negedge CLK);
    IN_VLD = 1'b0;
    RST    = 1'b1;
    #1;
    chk("midrst.vld", 64'(OUT_VLD), 64'd0);
    chk("midrst.i", 64'(OUT_DATI), 64'd0);
    chk("midrst.q", 64'(OUT_DATQ), 64'd0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    idle(2, "midrst.idle");
    step(1'b0, '0, 1'b1, 1'b0, '0, "midrst.clr");
    repeat (6) step(1'b1, $urandom, 1'b0, 1'b0, '0, "midrst.post");
    idle(4, "midrst.drain");

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/mix_ddc_nch.md
Name: mix_ddc_nch

Overview:
Parametrised N-channel digital down-conversion mixer with an internal programmable NCO. It replaces the fixed dual-channel mixer. It sits between the ADC capture logic and the decimating filters of the tracking front end. A phase accumulator drives a quarter-wave sin/cos LUT shared by all channels. Each channel produces rounded I (×cos) and Q (×sin) products, qualified by a valid strobe and run-time retunable.

Parameters:
NCH, 2, number of ADC channels
DW, 16, signed input sample width
CW, 16, signed NCO amplitude width
PW, 32, phase accumulator width
LUT_AW, 10, quarter-wave LUT address bits (LUT_AW+2 <= PW)
OW, 16, signed output width
OUT_SHIFT, 12, LSB index of the product slice taken as output (OUT_SHIFT >= 1)
FREQ_RST, 32'h4CCC_CCCD, phase increment after reset (0.3·fs)

Ports:
CLK  in  1  clock
RST  in  1  reset
IN_VLD  in  1  input sample strobe
IN_DAT  in  NCH*DW  channel k at [k*DW +: DW], two's complement
FREQ_WR  in  1  load FREQ_DAT into the increment shadow register
FREQ_DAT  in  PW  new phase increment
PHASE_CLR  in  1  zero the phase accumulator
OUT_VLD  out  1  output strobe
OUT_DATI  out  NCH*OW  I output, channel k at [k*OW +: OW]
OUT_DATQ  out  NCH*OW  Q output, same packing

Behaviour:
- Reset: RST is asynchronous, active-high; clock is CLK. On reset, all outputs and pipeline registers go to 0, the accumulator goes to 0, and the increment and shadow registers go to FREQ_RST. Reset asserted mid-stream discards all in-flight samples. OUT_VLD is 0 until 4 cycles after the first post-reset IN_VLD.
- Phase:
  - The sample accepted at IN_VLD uses the current accumulator value P.
  - The accumulator then becomes P+INC, mod 2^PW, with natural wrap.
  - With no IN_VLD, the accumulator holds.
- FREQ_WR: writes the shadow register. INC copies the shadow on the next IN_VLD cycle, so the new increment first affects the advance after that sample. FREQ_WR and IN_VLD in the same cycle: the written value becomes INC on the following IN_VLD.
- PHASE_CLR has priority over advance:
  - With IN_VLD: the sample uses phase 0 and the accumulator becomes INC.
  - Without IN_VLD: the accumulator becomes 0.
- LUT:
  - q = P[PW-1:PW-2]; a = P[PW-3 -: LUT_AW].
  - L[k] = round((2^(CW-1)-1)·sin(π/2·(k+0.5)/2^LUT_AW)).
  - q0: sin=L[a], cos=L[~a]
  - q1: sin=L[~a], cos=-L[a]
  - q2: sin=-L[a], cos=-L[~a]
  - q3: sin=-L[~a], cos=L[a]
  - Negation cannot overflow.
- Pipeline (the valid bit travels with the data; latency exactly 4 cycles; no back-pressure):
  - S1: registered LUT read, quadrant, input data.
  - S2: sign-corrected sin/cos.
  - S3: signed DW×CW products, registered.
  - S4: rounded and registered outputs.
- Rounding, per product p: out = p[OUT_SHIFT+OW-1:OUT_SHIFT] + p[OUT_SHIFT-1]. This is round-half-up, computed in OW bits. Default overflow behaviour is wrap (no saturation).
- Sample spacing: back-to-back IN_VLD supported every cycle. Gaps propagate as OUT_VLD=0 with OUT_DAT held.

Optional Feature:
MIX_SAT_EN:
- Defined: the rounded value is computed at full width (DW+CW-OUT_SHIFT+1 bits) and clamped to [-2^(OW-1), 2^(OW-1)-1].
- Undefined: plain OW-bit slice plus rounding bit, wrapping.
- Latency is unchanged in both builds.

Decomposition:
- Package mix_pkg holds:
  - quadrant encoding constants;
  - the round/saturate function, shared with future decimator stages;
  - default FREQ_RST.
- One sub-module, mix_sincos_lut: quarter-wave ROM plus quadrant mapping. It owns the S1/S2 registers and is parametrised by CW and LUT_AW. With default parameters, L[0]=25 and L[1023]=32767.

Test Plan:
- Constant phase (FREQ_WR 0 after PHASE_CLR), IN_DAT all channels = 1000, IN_VLD continuous -> from cycle 4, OUT_DATI = 8000, OUT_DATQ = 6, OUT_VLD=1.
- FREQ_DAT=32'h4000_0000, PHASE_CLR, input 1000 -> I sequence 8000, -6, -8000, 6 and Q sequence 6, 8000, -6, -8000, repeating.
- Input 32767, phase 0:
  - Without MIX_SAT_EN: I = 16'hFFF0 (-16).
  - With MIX_SAT_EN: I = 32767.
  - Input -32768 with MIX_SAT_EN: I = -32768.
- IN_VLD pattern 1,0,0,1 with FREQ_WR issued during the gap -> accumulator advances only on strobes. The new increment is first applied after the next strobed sample. OUT_VLD reproduces the pattern delayed by 4.
- Accumulator wrap, INC=32'hFFFF_FFFF -> phase decrements by 1 per sample; the mod 2^PW wrap through 0 shows no discontinuity in the outputs.
- RST pulse mid-stream with valid data in the pipeline -> all outputs 0 immediately. No OUT_VLD for the discarded samples. INC returns to 32'h4CCC_CCCD.
